// File: rtl/ps2_pkg.sv
// Shared PS/2 constants and types for the receive front end
// and the downstream keyboard-to-game mapping stage.
package ps2_pkg;

    localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
    localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_e;

    localparam logic [7:0] KEY_W     = 8'h1D;
    localparam logic [7:0] KEY_S     = 8'h1B;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_J     = 8'h3B;
    localparam logic [7:0] KEY_UP    = 8'h75;
    localparam logic [7:0] KEY_DOWN  = 8'h72;
    localparam logic [7:0] KEY_LEFT  = 8'h6B;
    localparam logic [7:0] KEY_RIGHT = 8'h74;
    localparam logic [7:0] KEY_SEMI  = 8'h4C;

endpackage

// File: rtl/ps2_clk_filter.sv
// 2-FF synchroniser and debounce filter for the raw PS/2 clock,
// producing a one-cycle pulse on each filtered falling edge.
module ps2_clk_filter #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic fall_tick
);

    logic                  meta;
    logic                  sync;
    logic                  level;
    logic [FILTER_LEN-1:0] hist;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta      <= 1'b0;
            sync      <= 1'b0;
            hist      <= '0;
            level     <= 1'b0;
            fall_tick <= 1'b0;
        end else begin
            meta      <= raw;
            sync      <= meta;
            hist      <= {hist[FILTER_LEN-2:0], sync};
            fall_tick <= 1'b0;
            if (&hist) begin
                level <= 1'b1;
            end else if (hist == '0) begin
                level     <= 1'b0;
                fall_tick <= level;
            end
        end
    end

endmodule

// File: rtl/ps2_rx_decoder.sv
// PS/2 frame receiver: deframes 11-bit frames, checks parity and stop,
// and folds E0/F0 prefixes into qualifiers on a strobed scan code.
module ps2_rx_decoder
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    output logic [7:0] code,
    output logic       code_break,
    output logic       code_ext,
    output logic       code_valid,
    output logic       frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYC);

    logic       data_meta;
    logic       data_sync;
    logic       fall_tick;

    ps2_state_e state;
    ps2_state_e state_next;

    logic [2:0]    bit_cnt;
    logic [7:0]    shreg;
    logic          par;
    logic [TW-1:0] tmo_cnt;
    logic          brk_pend;
    logic          ext_pend;

    logic timeout;
    logic stop_seen;
    logic frame_ok;
    logic frame_bad;

    ps2_clk_filter #(
        .FILTER_LEN(FILTER_LEN)
    ) u_filt (
        .clk      (clk),
        .reset    (reset),
        .raw      (ps2_clk),
        .fall_tick(fall_tick)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            data_meta <= 1'b0;
            data_sync <= 1'b0;
        end else begin
            data_meta <= ps2_data;
            data_sync <= data_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            ST_IDLE: begin
                if (fall_tick && !data_sync) state_next = ST_DATA;
            end
            ST_DATA: begin
                if (timeout) state_next = ST_IDLE;
                else if (fall_tick && bit_cnt == 3'd7) state_next = ST_PARITY;
            end
            ST_PARITY: begin
                if (timeout) state_next = ST_IDLE;
                else if (fall_tick) state_next = ST_STOP;
            end
            ST_STOP: begin
                if (timeout || fall_tick) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Timeout takes priority over a coincident edge: the frame is already stale.
    always_comb begin
        timeout   = (state != ST_IDLE) && (tmo_cnt == TMO_MAX);
        stop_seen = (state == ST_STOP) && fall_tick && !timeout;
        frame_ok  = stop_seen && data_sync && (^{shreg, par});
        frame_bad = (stop_seen && !frame_ok) || timeout;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bit_cnt    <= '0;
            shreg      <= '0;
            par        <= 1'b0;
            tmo_cnt    <= '0;
            brk_pend   <= 1'b0;
            ext_pend   <= 1'b0;
            code       <= '0;
            code_break <= 1'b0;
            code_ext   <= 1'b0;
            code_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            code_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (state == ST_IDLE || fall_tick || timeout) tmo_cnt <= '0;
            else tmo_cnt <= tmo_cnt + 1'b1;

            if (fall_tick) begin
                if (state == ST_IDLE) bit_cnt <= '0;
                if (state == ST_DATA) begin
                    shreg   <= {data_sync, shreg[7:1]};
                    bit_cnt <= bit_cnt + 3'd1;
                end
                if (state == ST_PARITY) par <= data_sync;
            end

            if (frame_ok) begin
                if (shreg == PS2_BREAK_CODE) begin
                    brk_pend <= 1'b1;
                end else if (shreg == PS2_EXT_CODE) begin
                    ext_pend <= 1'b1;
                end else begin
                    code       <= shreg;
                    code_break <= brk_pend;
                    code_ext   <= ext_pend;
                    code_valid <= 1'b1;
                    brk_pend   <= 1'b0;
                    ext_pend   <= 1'b0;
                end
            end else if (frame_bad) begin
                frame_err <= 1'b1;
                brk_pend  <= 1'b0;
                ext_pend  <= 1'b0;
            end
        end
    end

endmodule

// File: doc/ps2_rx_decoder.md
Name: ps2_rx_decoder

Overview:
PS/2 keyboard receive front end that feeds the keyboard-to-game mapping stage. It synchronises and filters ps2_clk and ps2_data, deframes each 11-bit frame, and checks odd parity and the stop bit. It then folds the 0xE0 (extended) and 0xF0 (break) prefix bytes into flags. Each completed key event leaves the block as a single-cycle-strobed scan code with make/break and extended qualifiers.

Parameters:
FILTER_LEN, 8, number of consecutive identical ps2_clk samples needed to change the filtered level (range 2..16)
TIMEOUT_CYC, 50000, clk cycles without a filtered falling edge before an in-progress frame is aborted (1 ms at 50 MHz)

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
ps2_clk  input  1  raw PS/2 clock from the connector, asynchronous
ps2_data  input  1  raw PS/2 data from the connector, asynchronous
code  output  8  last decoded scan code, prefix bytes excluded
code_break  output  1  1 when code was preceded by 0xF0 (key released)
code_ext  output  1  1 when code was preceded by 0xE0 (extended key, e.g. arrows)
code_valid  output  1  one-cycle strobe; code, code_break and code_ext are valid in this cycle
frame_err  output  1  one-cycle strobe on a parity, stop-bit or timeout error

Behaviour:
- Clock and reset: single clock domain clk; reset is synchronous and active-high and clears every register.
- Reset values: code=0x00, code_break=0, code_ext=0, code_valid=0, frame_err=0. FSM goes to IDLE, prefix flags clear, timeout counter is 0. A reset mid-frame discards the partial frame with no strobe.
- Input synchronisation: ps2_clk and ps2_data each pass through a 2-FF synchroniser.
- Clock filter: a FILTER_LEN-deep shift register samples the synchronised ps2_clk. The filtered level goes to 0 only when all samples are 0, and to 1 only when all are 1; otherwise it holds. fall_tick is a 1-cycle pulse on a filtered 1->0 transition. The synchronised ps2_data is sampled only in the fall_tick cycle.
- FSM states: IDLE, DATA, PARITY, STOP.
  - IDLE, fall_tick with data=0 (start bit): go to DATA, bit_cnt=0.
  - IDLE, fall_tick with data=1: ignored; stay in IDLE with no error.
  - DATA: shift data in LSB first on each fall_tick. After the 8th bit, go to PARITY.
  - PARITY: latch the parity bit, go to STOP.
  - STOP: on fall_tick, the frame is good if the stop bit is 1 and the XOR of the 8 data bits and the parity bit is 1 (odd parity). Return to IDLE either way.
- Good frame, byte 0xF0: set brk_pend; no strobe.
- Good frame, byte 0xE0: set ext_pend; no strobe.
- Good frame, any other byte (including 0xE1): in the next cycle, code takes the byte, code_break takes brk_pend, code_ext takes ext_pend, and code_valid pulses for 1 cycle. Both pending flags clear in that same cycle.
- Prefix order is not checked: E0 F0 xx and F0 E0 xx give identical results.
- Latency: code_valid rises exactly 1 clk after the fall_tick of the stop bit.
- Bad frame (parity or stop-bit error): frame_err pulses 1 cycle after the stop fall_tick. brk_pend and ext_pend clear, code_valid stays 0, and code, code_break and code_ext hold their values.
- Timeout: the counter runs in DATA, PARITY and STOP and resets to 0 on each fall_tick. When it reaches TIMEOUT_CYC, the FSM goes to IDLE, frame_err pulses for 1 cycle, and the pending flags clear. The counter is held at 0 in IDLE. Counter width is $clog2(TIMEOUT_CYC+1).
- Output hold: code, code_break and code_ext keep their values between strobes. code_valid and frame_err are never high in the same cycle.
- Scope: receive only; the block never drives the PS/2 lines.

Decomposition:
- Shared package ps2_pkg:
  - PS2_BREAK_CODE=8'hF0, PS2_EXT_CODE=8'hE0
  - FSM state typedef (IDLE/DATA/PARITY/STOP)
  - game key scan-code constants (W=1D, S=1B, A=1C, D=23, J=3B, arrows 75/72/6B/74, 4C), shared with the downstream mapping stage
- One sub-module, ps2_clk_filter: 2-FF synchroniser plus FILTER_LEN debounce plus fall_tick generation. It is instantiated for ps2_clk; ps2_data uses only the 2-FF synchroniser.

Test Plan:
- Frame 0x1D, parity 1, stop 1 (bit period 40 us, clk 50 MHz) -> one code_valid pulse 1 clk after the stop edge; code=0x1D, code_break=0, code_ext=0; frame_err stays 0.
- Frames F0 then 1D -> no strobe after F0; one strobe after 1D with code=0x1D, code_break=1, code_ext=0.
- Frames E0 75, then E0 F0 75 -> first strobe code=0x75, code_ext=1, code_break=0; second strobe code=0x75, code_ext=1, code_break=1; exactly 2 strobes in total.
- Frame F0, then 0x23 with parity bit 1 (bad), then 0x1D -> frame_err pulses once with no strobe on the bad frame; the 0x1D strobe has code_break=0 because the pending flag was cleared.
- Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT_CYC+10 cycles -> one frame_err pulse after TIMEOUT_CYC cycles. A following good 0x1C frame -> code=0x1C, code_valid pulses once.
- ps2_clk low glitch of FILTER_LEN-2 cycles mid-frame -> no extra bit is shifted and the frame still decodes as 0x1D. Asserting reset at bit 5 of a frame -> all outputs 0, with no strobe for that frame.
